// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 memory slave front-end.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StBresp
  } state_e;

  typedef enum logic {
    PrioWrite,
    PrioRead
  } prio_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus (AW/W/B/AR/R) between an interconnect master port and the memory slave.
interface axi_mem_slave_if #(
  parameter int unsigned IdsBits  = 8,
  parameter int unsigned DataBits = 32,
  parameter int unsigned LenBits  = 4
);
  logic [IdsBits-1:0]    awid;
  logic [31:0]           awaddr;
  logic [LenBits-1:0]    awlen;
  logic                  awvalid;
  logic                  awready;
  logic [DataBits-1:0]   wdata;
  logic [DataBits/8-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [IdsBits-1:0]    bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [IdsBits-1:0]    arid;
  logic [31:0]           araddr;
  logic [LenBits-1:0]    arlen;
  logic                  arvalid;
  logic                  arready;
  logic [IdsBits-1:0]    rid;
  logic [DataBits-1:0]   rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_buf.sv
// Two-entry read-data FIFO; simultaneous push and pop are allowed.
module axi_rd_buf #(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);
  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave front-end for a single-port synchronous memory: INCR bursts, one transaction
// at a time, alternating write/read priority, optional read-only mode.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned AddrBits = 14,
  parameter int unsigned DataBits = 32,
  parameter int unsigned IdsBits  = 8,
  parameter int unsigned LenBits  = 4,
  parameter bit          ReadOnly = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  axi_mem_slave_if.slave        axi,
  output logic                  mem_cs_o,
  output logic                  mem_oe_o,
  output logic [DataBits/8-1:0] mem_web_o,
  output logic [AddrBits-1:0]   mem_addr_o,
  output logic [DataBits-1:0]   mem_di_o,
  input  logic [DataBits-1:0]   mem_do_i
);
  localparam int unsigned Ofs = $clog2(DataBits / 8);

  state_e               state_q, state_d;
  prio_e                prio_q, prio_d;
  logic [IdsBits-1:0]   id_q, id_d;
  logic [LenBits-1:0]   len_q, len_d;
  logic [AddrBits-1:0]  addr_q, addr_d;
  logic [LenBits:0]     cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic                 err_q, err_d;

  logic                 aw_grant, ar_grant, rd_issue, buf_pop;
  logic [1:0]           buf_count;
  logic [2:0]           rd_occ;
  logic [DataBits:0]    buf_data;
  logic [AddrBits-1:0]  beat_addr;
  logic [LenBits:0]     len_ext;
  logic                 unused_addr;

  assign len_ext   = {1'b0, len_q};
  assign beat_addr = addr_q + AddrBits'(cnt_q);
  assign aw_grant  = (state_q == StIdle) && axi.awvalid && (!axi.arvalid || prio_q == PrioWrite);
  assign ar_grant  = (state_q == StIdle) && axi.arvalid && (!axi.awvalid || prio_q == PrioRead);
  assign buf_pop   = axi.rvalid && axi.rready;
  // The slot freed by this cycle's pop is counted so the buffer streams one beat per cycle.
  assign rd_occ    = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, buf_pop};
  assign rd_issue  = (state_q == StRd) && (cnt_q <= len_ext) && (rd_occ < 3'd2);
  assign unused_addr = ^{axi.awaddr, axi.araddr};

  axi_rd_buf #(
    .Width (DataBits + 1)
  ) u_rd_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, mem_do_i}),
    .pop_i   (buf_pop),
    .data_o  (buf_data),
    .count_o (buf_count)
  );

  assign axi.awready = aw_grant;
  assign axi.arready = ar_grant;
  assign axi.rvalid  = (buf_count != 2'd0);
  assign axi.rdata   = buf_data[DataBits-1:0];
  assign axi.rlast   = axi.rvalid && buf_data[DataBits];
  assign axi.rid     = id_q;
  assign axi.rresp   = RespOkay;
  assign axi.bid     = id_q;

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    id_d            = id_q;
    len_d           = len_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (cnt_q == len_ext);
    axi.wready      = 1'b0;
    axi.bvalid      = 1'b0;
    axi.bresp       = RespOkay;
    mem_cs_o        = 1'b0;
    mem_oe_o        = 1'b0;
    mem_web_o       = '1;
    mem_addr_o      = '0;
    mem_di_o        = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (aw_grant) begin
          id_d    = axi.awid;
          len_d   = axi.awlen;
          addr_d  = axi.awaddr[AddrBits+Ofs-1:Ofs];
          state_d = StWr;
        end else if (ar_grant) begin
          id_d    = axi.arid;
          len_d   = axi.arlen;
          addr_d  = axi.araddr[AddrBits+Ofs-1:Ofs];
          state_d = StRd;
        end
      end
      StRd: begin
        if (rd_issue) begin
          mem_cs_o   = 1'b1;
          mem_oe_o   = 1'b1;
          mem_addr_o = beat_addr;
          cnt_d      = cnt_q + {{LenBits{1'b0}}, 1'b1};
        end
        if (buf_pop && axi.rlast) begin
          state_d = StIdle;
          prio_d  = PrioWrite;
        end
      end
      StWr: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          if (!ReadOnly) begin
            mem_cs_o   = 1'b1;
            mem_web_o  = ~axi.wstrb;
            mem_addr_o = beat_addr;
            mem_di_o   = axi.wdata;
          end
          cnt_d = cnt_q + {{LenBits{1'b0}}, 1'b1};
          if (axi.wlast) begin
            err_d   = ReadOnly || (cnt_q != len_ext);
            state_d = StBresp;
          end
        end
      end
      StBresp: begin
        axi.bvalid = 1'b1;
        axi.bresp  = err_q ? RespSlverr : RespOkay;
        if (axi.bready) begin
          state_d = StIdle;
          prio_d  = PrioRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      prio_q          <= PrioWrite;
      id_q            <= '0;
      len_q           <= '0;
      addr_q          <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      id_q            <= id_d;
      len_q           <= len_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      err_q           <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench: a read-write and a read-only slave (16-word memories) share one stimulus bus.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  axi_mem_slave_if #(.IdsBits(8), .DataBits(32), .LenBits(4)) ifa ();
  axi_mem_slave_if #(.IdsBits(8), .DataBits(32), .LenBits(4)) ifb ();

  assign ifb.awid    = ifa.awid;
  assign ifb.awaddr  = ifa.awaddr;
  assign ifb.awlen   = ifa.awlen;
  assign ifb.awvalid = ifa.awvalid;
  assign ifb.wdata   = ifa.wdata;
  assign ifb.wstrb   = ifa.wstrb;
  assign ifb.wlast   = ifa.wlast;
  assign ifb.wvalid  = ifa.wvalid;
  assign ifb.bready  = ifa.bready;
  assign ifb.arid    = ifa.arid;
  assign ifb.araddr  = ifa.araddr;
  assign ifb.arlen   = ifa.arlen;
  assign ifb.arvalid = ifa.arvalid;
  assign ifb.rready  = ifa.rready;

  logic        mem_cs_a, mem_oe_a, mem_cs_b, mem_oe_b;
  logic [3:0]  mem_web_a, mem_web_b, mem_addr_a, mem_addr_b;
  logic [31:0] mem_di_a, mem_di_b, mem_do_a, mem_do_b;

  axi_mem_slave #(
    .AddrBits(4), .DataBits(32), .IdsBits(8), .LenBits(4), .ReadOnly(1'b0)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .axi(ifa), .mem_cs_o(mem_cs_a), .mem_oe_o(mem_oe_a),
    .mem_web_o(mem_web_a), .mem_addr_o(mem_addr_a), .mem_di_o(mem_di_a), .mem_do_i(mem_do_a)
  );

  axi_mem_slave #(
    .AddrBits(4), .DataBits(32), .IdsBits(8), .LenBits(4), .ReadOnly(1'b1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .axi(ifb), .mem_cs_o(mem_cs_b), .mem_oe_o(mem_oe_b),
    .mem_web_o(mem_web_b), .mem_addr_o(mem_addr_b), .mem_di_o(mem_di_b), .mem_do_i(mem_do_b)
  );

  function automatic logic [31:0] init_word(input int w);
    return (w == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + w;
  endfunction

  // Memory macro models: read data one cycle after cs&oe, byte writes on active-low web.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  bit          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
      mem_loaded <= 1'b1;
    end else begin
      if (mem_cs_a && mem_oe_a) mem_do_a <= mem_a[mem_addr_a];
      if (mem_cs_b && mem_oe_b) mem_do_b <= mem_b[mem_addr_b];
      for (int b = 0; b < 4; b++) begin
        if (mem_cs_a && !mem_web_a[b]) mem_a[mem_addr_a][8*b +: 8] <= mem_di_a[8*b +: 8];
        if (mem_cs_b && !mem_web_b[b]) mem_b[mem_addr_b][8*b +: 8] <= mem_di_b[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic reset_checks();
    check_eq("rst_ready", {ifa.awready, ifa.arready, ifa.wready}, 0);
    check_eq("rst_valid", {ifa.bvalid, ifa.rvalid, ifa.rlast}, 0);
    check_eq("rst_ids", {ifa.rid, ifa.bid}, 0);
    check_eq("rst_rdata", ifa.rdata, 0);
    check_eq("rst_resp", {ifa.rresp, ifa.bresp}, 0);
    check_eq("rst_mem", {mem_cs_a, mem_oe_a, mem_web_a, mem_addr_a}, 10'b00_1111_0000);
    check_eq("rst_di", mem_di_a, 0);
    check_eq("rst_mem_b", {mem_cs_b, mem_web_b}, 5'h0F);
  endtask

  task automatic ar_req(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit ok = 1'b0;
    ifa.arid = id; ifa.araddr = addr; ifa.arlen = len; ifa.arvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = ifa.arready;
      @(posedge clk); #1;
    end
    check_eq("ar_handshake", ok, 1);
    ifa.arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit ok = 1'b0;
    ifa.awid = id; ifa.awaddr = addr; ifa.awlen = len; ifa.awvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = ifa.awready;
      @(posedge clk); #1;
    end
    check_eq("aw_handshake", ok, 1);
    ifa.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] waddr);
    bit         ok = 1'b0;
    logic [3:0] nstrb;
    nstrb = ~strb;
    ifa.wdata = data; ifa.wstrb = strb; ifa.wlast = last; ifa.wvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = ifa.wready;
      if (ok) begin
        check_eq("w_cs_a", {mem_cs_a, mem_oe_a}, 2'b10);
        check_eq("w_web_a", mem_web_a, nstrb);
        check_eq("w_addr_a", mem_addr_a, waddr);
        check_eq("w_di_a", mem_di_a, data);
        check_eq("w_idle_b", {mem_cs_b, mem_web_b}, 5'h0F);
      end
      @(posedge clk); #1;
    end
    check_eq("w_handshake", ok, 1);
    ifa.wvalid = 1'b0; ifa.wlast = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_a, input logic [1:0] exp_b, input logic [7:0] id);
    bit ok = 1'b0;
    ifa.bready = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = ifa.bvalid;
      if (ok) begin
        check_eq("bresp_a", ifa.bresp, exp_a);
        check_eq("bresp_b", {ifb.bvalid, ifb.bresp}, {1'b1, exp_b});
        check_eq("bid", ifa.bid, id);
      end
      @(posedge clk); #1;
    end
    check_eq("b_handshake", ok, 1);
    ifa.bready = 1'b0;
  endtask

  // Receives n beats starting at word base, checking issue addresses and head data each cycle.
  task automatic r_burst(input int n, input int base, input bit toggle, input logic [7:0] id);
    int k = 0;
    int iss = 0;
    for (int cyc = 0; cyc < 200 && k < n; cyc++) begin
      ifa.rready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (mem_cs_a) begin
        check_eq("rd_addr", mem_addr_a, (base + iss) % 16);
        iss++;
      end
      if (ifa.rvalid) begin
        check_eq("rdata", ifa.rdata, init_word((base + k) % 16));
        check_eq("rlast", ifa.rlast, (k == n - 1));
        check_eq("rid_rresp", {ifa.rid, ifa.rresp}, {id, 2'b00});
        if (ifa.rready) k++;
      end
      @(posedge clk); #1;
    end
    ifa.rready = 1'b0;
    check_eq("r_beats", k, n);
    check_eq("r_issued", iss, n);
  endtask

  initial begin
    int g;
    rst_ni = 1'b0;
    ifa.awid = '0; ifa.awaddr = '0; ifa.awlen = '0; ifa.awvalid = 1'b0;
    ifa.wdata = '0; ifa.wstrb = '0; ifa.wlast = 1'b0; ifa.wvalid = 1'b0; ifa.bready = 1'b0;
    ifa.arid = '0; ifa.araddr = '0; ifa.arlen = '0; ifa.arvalid = 1'b0; ifa.rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Single read: word 4, data appears two edges after the AR handshake.
    ar_req(8'h5A, 32'h10, 4'd0);
    ifa.rready = 1'b1;
    @(negedge clk);
    check_eq("single_issue", {mem_cs_a, mem_oe_a, mem_addr_a}, {2'b11, 4'd4});
    check_eq("single_rv_c1", ifa.rvalid, 0);
    @(negedge clk);
    check_eq("single_rv_c2", {ifa.rvalid, mem_cs_a}, 0);
    @(negedge clk);
    check_eq("single_rv_c3", ifa.rvalid, 1);
    check_eq("single_rdata", ifa.rdata, 32'hDEAD_BEEF);
    check_eq("single_rdata_b", ifb.rdata, 32'hDEAD_BEEF);
    check_eq("single_last_resp_id", {ifa.rlast, ifa.rresp, ifa.rid}, {1'b1, 2'b00, 8'h5A});
    @(negedge clk);
    check_eq("single_done", ifa.rvalid, 0);
    @(posedge clk); #1;
    ifa.rready = 1'b0;

    // Full 16-beat burst with RREADY toggling.
    ar_req(8'h21, 32'h0, 4'd15);
    r_burst(16, 0, 1'b1, 8'h21);

    // AW and AR held together: grants alternate starting with write.
    ifa.awid = 8'h31; ifa.awaddr = 32'h30; ifa.awlen = 4'd0; ifa.awvalid = 1'b1;
    ifa.arid = 8'h41; ifa.araddr = 32'h34; ifa.arlen = 4'd0; ifa.arvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = -1;
      for (int c = 0; c < 20 && g < 0; c++) begin
        @(negedge clk);
        if (ifa.awready || ifa.arready) begin
          check_eq("grant_one_hot", {ifa.awready, ifa.arready} == 2'b11, 0);
          g = ifa.awready ? 0 : 1;
        end
        @(posedge clk); #1;
      end
      check_eq("grant_order", g, t % 2);
      if (t == 3) begin
        ifa.awvalid = 1'b0; ifa.arvalid = 1'b0;
      end
      if (g == 0) begin
        w_beat(32'h5555_5555, 4'b0000, 1'b1, 4'd12);
        wait_b(2'b00, 2'b10, 8'h31);
      end else if (g == 1) begin
        r_burst(1, 13, 1'b0, 8'h41);
      end
    end
    ifa.awvalid = 1'b0; ifa.arvalid = 1'b0;

    // Four-beat write with lower-half strobes.
    aw_req(8'h77, 32'h20, 4'd3);
    for (int i = 0; i < 4; i++) w_beat(32'hCAFE_1110 + i, 4'b0011, i == 3, 4'(8 + i));
    wait_b(2'b00, 2'b10, 8'h77);
    for (int i = 0; i < 4; i++) begin
      check_eq("mem_a_word", mem_a[8 + i], 32'hA000_1110 + i);
      check_eq("mem_b_word", mem_b[8 + i], 32'hA000_0008 + i);
    end

    // WLAST on beat 1 of a four-beat burst.
    aw_req(8'h22, 32'h20, 4'd3);
    w_beat(32'h0000_0001, 4'b1111, 1'b0, 4'd8);
    w_beat(32'h0000_0002, 4'b1111, 1'b1, 4'd9);
    wait_b(2'b10, 2'b10, 8'h22);

    // Address wrap: word 15 then word 0.
    ar_req(8'h0C, 32'h3C, 4'd1);
    r_burst(2, 15, 1'b0, 8'h0C);

    // Reset with a stalled burst in flight, then a normal read.
    ar_req(8'h55, 32'h0, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_rvalid", ifa.rvalid, 1);
    rst_ni = 1'b0;
    #1;
    reset_checks();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    ar_req(8'h66, 32'h8, 4'd0);
    r_burst(1, 2, 1'b0, 8'h66);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
